// File: rtl/kcpsm_port_bank.sv
// KCPSM6 I/O port bank: decoded output registers with write pulses, registered
// input mux, and a sticky read-to-clear event register that drives the interrupt.
module kcpsm_port_bank #(
    parameter int               DATA_W    = 8,
    parameter int               N_OUT     = 16,
    parameter int               N_IN      = 4,
    parameter int               N_EV      = 8,
    parameter logic [7:0]       OUT_BASE  = 8'h00,
    parameter logic [7:0]       IN_BASE   = 8'h00,
    parameter logic [7:0]       EVT_PORT  = 8'hF0,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               port_id,
    input  logic [DATA_W-1:0]        out_port,
    input  logic                     write_strobe,
    input  logic                     k_write_strobe,
    input  logic                     read_strobe,
    output logic [DATA_W-1:0]        in_port,
    output logic [N_OUT*DATA_W-1:0]  out_regs,
    output logic [N_OUT-1:0]         wr_pulse,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_EV-1:0]          ev_in,
    output logic                     interrupt,
    input  logic                     interrupt_ack
);

    // OUTPUTK only carries a 4-bit address, so at most 16 registers are reachable by it.
    localparam int N_K     = (N_OUT < 16) ? N_OUT : 16;
    localparam int OUT_END = int'(OUT_BASE) + N_OUT;
    localparam int IN_END  = int'(IN_BASE) + N_IN;

    if (N_OUT < 1 || N_OUT > 64) begin : g_bad_n_out
        $error("kcpsm_port_bank: N_OUT out of range 1..64");
    end
    if (N_IN < 1 || N_IN > 64) begin : g_bad_n_in
        $error("kcpsm_port_bank: N_IN out of range 1..64");
    end
    if (N_EV < 1 || N_EV > DATA_W) begin : g_bad_n_ev
        $error("kcpsm_port_bank: N_EV out of range 1..DATA_W");
    end
    if (OUT_END > 256) begin : g_bad_out_wrap
        $error("kcpsm_port_bank: output port range wraps past 8'hFF");
    end
    if (IN_END > 256) begin : g_bad_in_wrap
        $error("kcpsm_port_bank: input port range wraps past 8'hFF");
    end
    if ((int'(EVT_PORT) >= int'(OUT_BASE) && int'(EVT_PORT) < OUT_END) ||
        (int'(EVT_PORT) >= int'(IN_BASE) && int'(EVT_PORT) < IN_END)) begin : g_bad_evt
        $error("kcpsm_port_bank: EVT_PORT overlaps an output or input range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irq_state_t;

    logic [N_OUT-1:0]  wr_sel_s;
    logic              mask_wr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [N_EV-1:0]   rise_s;
    logic              ev_clr_s;
    logic              irq_hit_s;

    irq_state_t        state_r;
    logic [N_EV-1:0]   flags_r;
    logic [N_EV-1:0]   mask_r;
    logic [N_EV-1:0]   ev_prev_r;

    // Write address decode; write_strobe takes priority over k_write_strobe.
    always_comb begin
        wr_sel_s = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            wr_sel_s[i] = (write_strobe && (port_id == OUT_BASE + 8'(i))) ||
                          (!write_strobe && k_write_strobe && (i < N_K) &&
                           (port_id[3:0] == 4'(i)));
        end
        mask_wr_s = write_strobe && (port_id == EVT_PORT);
    end

    // Read mux as an AND-OR tree; unmatched addresses collapse to zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int j = 0; j < N_IN; j++) begin
            rd_data_s = rd_data_s |
                        ({DATA_W{port_id == IN_BASE + 8'(j)}} & in_data[j*DATA_W +: DATA_W]);
        end
        rd_data_s = rd_data_s | ({DATA_W{port_id == EVT_PORT}} & DATA_W'(flags_r));
    end

    assign rise_s    = ev_in & ~ev_prev_r;
    assign ev_clr_s  = read_strobe && (port_id == EVT_PORT);
    assign irq_hit_s = |(rise_s & mask_r);

    // Output registers, write pulses and the registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_regs <= {N_OUT{RESET_VAL}};
            wr_pulse <= {N_OUT{1'b0}};
            in_port  <= {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_sel_s[i]) begin
                    out_regs[i*DATA_W +: DATA_W] <= out_port;
                end
            end
            wr_pulse <= wr_sel_s;
            in_port  <= rd_data_s;
        end
    end

    // Sticky event flags: a rise in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r   <= {N_EV{1'b0}};
            mask_r    <= {N_EV{1'b0}};
            ev_prev_r <= {N_EV{1'b0}};
        end else begin
            flags_r   <= (ev_clr_s ? {N_EV{1'b0}} : flags_r) | rise_s;
            ev_prev_r <= ev_in;
            if (mask_wr_s) begin
                mask_r <= out_port[N_EV-1:0];
            end
        end
    end

    // Interrupt handshake; only fresh masked rises arm it, so mask writes never do.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            interrupt <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (irq_hit_s) begin
                        state_r   <= PEND;
                        interrupt <= 1'b1;
                    end
                end
                PEND: begin
                    if (interrupt_ack && !irq_hit_s) begin
                        state_r   <= IDLE;
                        interrupt <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/kcpsm_port_bank.md
Name: kcpsm_port_bank

Overview:
- Parametrised PicoBlaze (KCPSM6) I/O port bank, placed between the processor and the peripheral controllers (RTC, PS/2, VGA).
- Replaces hand-written per-port decode with the following:
  - N_OUT registered output ports with full 8-bit address decode.
  - N_IN registered input ports.
  - k_write_strobe (constant-output) support.
  - Per-port write pulses.
  - A sticky event/status register with mask and interrupt generation, handshaked through interrupt_ack.

Parameters:
DATA_W, 8, port data width (= KCPSM6 out_port width)
N_OUT, 16, number of output registers, 1..64
N_IN, 4, number of input ports, 1..64
N_EV, 8, number of event inputs, 1..DATA_W
OUT_BASE, 8'h00, port_id of output register 0
IN_BASE, 8'h00, port_id of input port 0
EVT_PORT, 8'hF0, status (read) / mask (write) port; must lie outside the OUT_BASE and IN_BASE ranges
RESET_VAL, 0, reset value of every output register

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
port_id  in  8  KCPSM6 port address
out_port  in  DATA_W  KCPSM6 write data
write_strobe  in  1  normal OUTPUT strobe
k_write_strobe  in  1  OUTPUTK strobe (only port_id[3:0] meaningful)
read_strobe  in  1  INPUT strobe
in_port  out  DATA_W  registered read data to KCPSM6
out_regs  out  N_OUT*DATA_W  flat output registers, reg i at [i*DATA_W +: DATA_W]
wr_pulse  out  N_OUT  one-cycle pulse per register written
in_data  in  N_IN*DATA_W  flat input ports, port j at [j*DATA_W +: DATA_W]
ev_in  in  N_EV  event lines, synchronous to clk
interrupt  out  1  to KCPSM6 interrupt
interrupt_ack  in  1  from KCPSM6 interrupt_ack

Behaviour:

Reset (synchronous, active-high):
- out_regs = RESET_VAL.
- wr_pulse, in_port, flags, mask, interrupt, ev_prev = 0.
- Reset overrides every strobe in the same cycle.

Write decode:
- write_strobe with port_id == OUT_BASE+i (0 <= i < N_OUT): reg i <= out_port on the next edge; wr_pulse[i] = 1 for exactly that cycle, aligned with the new value.
- k_write_strobe with port_id[3:0] == i (i < min(16, N_OUT)): same update, ignoring OUT_BASE and port_id[7:4].
- Unmatched addresses: no change, no pulse.
- write_strobe and k_write_strobe are never both asserted; if they are, write_strobe wins.
- write_strobe with port_id == EVT_PORT: mask <= out_port[N_EV-1:0]. Not reachable via k_write_strobe.

Read path:
- in_port is registered every cycle from port_id; valid one cycle after port_id is presented, which meets KCPSM6 two-cycle INPUT timing.
- port_id in IN_BASE..IN_BASE+N_IN-1: in_port <= in_data[port j].
- port_id == EVT_PORT: in_port <= zero-extended flags.
- Any other address: in_port <= 0 (never X).

Events:
- ev_prev <= ev_in each cycle; rise = ev_in & ~ev_prev.
- flags[k] is set on rise[k], regardless of mask.
- read_strobe with port_id == EVT_PORT clears flags, read-to-clear, on the same edge the strobe is sampled. The value returned was captured the cycle before.
- A rise in the same cycle as the clear leaves that bit set (set wins).

Interrupt (two states, IDLE / PEND):
- IDLE -> PEND when (rise & mask) != 0; interrupt = 1 in PEND.
- PEND -> IDLE on interrupt_ack.
- If interrupt_ack coincides with a new masked rise, stay in PEND.
- A mask write does not itself raise the interrupt; pre-existing flags under a newly set mask bit do not trigger.
- interrupt_ack in IDLE is ignored.

Widths:
- Address arithmetic OUT_BASE+i and IN_BASE+j is 8-bit. Ranges that wrap past 8'hFF are illegal; flag this with an elaboration check.

Test Plan:
1. Reset, then write_strobe with port_id=8'h03, out_port=8'hA5 -> reg 3 = 8'hA5 next cycle, wr_pulse = 16'h0008 for one cycle, other regs = RESET_VAL.
2. k_write_strobe with port_id=8'hF7, out_port=8'h3C -> reg 7 = 8'h3C; write_strobe with port_id=8'h47 (N_OUT=16, OUT_BASE=0) -> no register changes, wr_pulse = 0.
3. IN_BASE=8'h00, in_data port 2 = 8'h5A, port_id=8'h02 -> in_port = 8'h5A one cycle later; port_id=8'h10 -> in_port = 8'h00.
4. mask=8'h01; pulse ev_in[3] -> flags = 8'h08, interrupt stays 0; pulse ev_in[0] -> interrupt = 1 the next cycle; interrupt_ack -> interrupt = 0; read EVT_PORT -> in_port = 8'h09, then flags = 0.
5. Rise on ev_in[1] in the same cycle as an EVT_PORT read_strobe -> flags = 8'h02 afterwards; interrupt_ack coincident with a masked rise -> interrupt remains 1.
6. Reset asserted in the same cycle as write_strobe to port 0 and a masked rise -> reg 0 = RESET_VAL, flags = 0, interrupt = 0.
